// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder/subtractor: one CHUNK-bit slice per clock with a
// registered inter-slice carry; start/busy/done handshake to the sequencer.
module multicycle_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o,
    output logic             ovf_o
);
    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CW-1:0]    cnt_q;

    logic [CHUNK:0]   slice_d;
    logic [WIDTH-1:0] res_d;
    logic             msb_cin_d;

    always_comb begin
        slice_d   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        // Slice sum enters from the top so after N slices the result is aligned.
        res_d     = (res_q >> CHUNK) | (WIDTH'(slice_d[CHUNK-1:0]) << (WIDTH - CHUNK));
        // Carry into the slice MSB recovered from its sum bit and operand bits.
        msb_cin_d = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice_d[CHUNK-1];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i | c_in_i;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    res_q   <= res_d;
                    carry_q <= slice_d[CHUNK];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= slice_d[CHUNK];
                        ovf_q   <= msb_cin_d ^ slice_d[CHUNK];
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q == BUSY);
    assign done_o  = (state_q == DONE);
    assign sum_o   = sum_q;
    assign c_out_o = cout_q;
    assign ovf_o   = ovf_q;
endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised, multi-cycle ripple adder/subtractor built from CHUNK-bit slices of full-adder logic. It processes one CHUNK-bit slice per clock, carrying between slices through a registered carry. A WIDTH-bit operation completes in WIDTH/CHUNK cycles, trading latency for area. It sits beside the datapath ALU as the wide add/subtract engine, driven by a start/busy/done handshake from the control sequencer.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK is the cycles per operation.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; sampled only in IDLE or DONE.
- sub_i  in  1  0 = add, 1 = subtract; captured with start_i.
- a_i  in  WIDTH  operand A; captured with start_i.
- b_i  in  WIDTH  operand B; captured with start_i.
- c_in_i  in  1  carry-in for add; ignored when sub_i=1.
- busy_o  out  1  high while slices are being processed.
- done_o  out  1  one-cycle pulse when results update.
- sum_o  out  WIDTH  result; holds until the next completion.
- c_out_o  out  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf_o  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States are IDLE, BUSY and DONE. A slice counter runs from 0 to N-1.
- IDLE, start_i=1:
  - Load internal A and B registers; B is loaded as ~b_i when sub_i=1.
  - Carry register = sub_i ? 1 : c_in_i.
  - Counter = 0; go to BUSY.
- BUSY, each edge:
  - Add the low CHUNK bits of A and B plus the carry register.
  - Shift the slice sum into the result shift register from the top; shift A and B right by CHUNK.
  - Carry register = slice carry-out; counter increments.
- BUSY, edge processing slice N-1:
  - Load sum_o from the full result; set c_out_o from the final carry.
  - ovf_o = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Go to DONE.
- DONE: lasts exactly one cycle.
  - start_i=1: capture new operands exactly as in IDLE; go to BUSY.
  - Otherwise go to IDLE.
- Ignored inputs:
  - start_i in BUSY is ignored. Operands are not re-sampled and the operation in flight is unaffected.
  - Changes on a_i, b_i, sub_i and c_in_i outside a capturing edge have no effect.
- Arithmetic is modulo 2^WIDTH. The subtract result is A + ~B + 1.
- Outputs are decoded from state: busy_o = (state==BUSY), done_o = (state==DONE).
- sum_o, c_out_o and ovf_o are registered and change only on the completing edge.

## Timing
- Reset (rst_n_i low, asynchronous) clears everything:
  - State = IDLE and counter = 0.
  - busy_o=0, done_o=0, sum_o=0, c_out_o=0, ovf_o=0.
  - Internal operand, result and carry registers = 0.
- Reset asserted mid-BUSY aborts the operation. No done_o pulse follows and outputs read 0.
- Reset is released synchronously to clk_i by the system; the first usable start_i edge is the first edge after release.
- Latency:
  - start_i sampled at edge E0. busy_o is high from E0 until EN (N cycles).
  - Results and done_o appear at EN; done_o falls at EN+1.
- Throughput: with start_i held high, a new operation is captured every N+1 edges.
- N=1 (CHUNK=WIDTH): one BUSY cycle, then DONE. This is the degenerate single-cycle adder.

## Test plan
(WIDTH=32, CHUNK=8, N=4 unless stated.)
- Add with full carry chain: 0xFFFFFFFF + 0x00000001, c_in=0 → sum_o=0x00000000, c_out_o=1, ovf_o=0. done_o pulses exactly 4 cycles after the start edge; busy_o is high for 4 cycles.
- Signed overflow and carry-in: 0x7FFFFFFF + 0x00000000, c_in=1 → sum_o=0x80000000, c_out_o=0, ovf_o=1. Also 0x000000FF + 0x00000001 → 0x00000100, exercising the carry across a slice boundary.
- Subtract, borrow and no-borrow:
  - 5 − 7 with c_in_i=1 (must be ignored) → 0xFFFFFFFE, c_out_o=0, ovf_o=0.
  - 7 − 5 → 0x00000002, c_out_o=1.
  - 0x80000000 − 1 → 0x7FFFFFFF, ovf_o=1.
- Start during BUSY: start 1+2, then pulse start_i with 9+9 on the next cycle → result 3. Only one done_o pulse; sum_o stays 3 afterward.
- Reset mid-operation: assert rst_n_i low at counter=2 → busy_o=0, all outputs 0, no done_o pulse. After release, 3+4 → 7 with the normal 4-cycle latency.
- Back-to-back and parameter sweep:
  - start_i held high with changing operands → done_o pulses every 5 cycles with the correct results.
  - Repeat the add/subtract vectors with CHUNK=32 (latency 1) and CHUNK=1 (latency 32).
